// File: rtl/breastcancer2b_feature_loader.sv
// Purpose : quantizes a stream of raw features to 2 bits each and presents one 7-feature frame to the 2-bit TNN neuron.
// Latency : out_valid rises the cycle after the 7th accepted sample; err_frame pulses the cycle after a bad accept.
// Backpres: s_ready drops while a frame is held; the frame stays stable until out_valid & out_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last  raw sample stream, s_last marks feature 6
//   thr_we/thr_feat/thr_lvl/thr_data  threshold table write port (feat 7 / lvl 3 ignored)
//   q_a..q_g                 quantized features 0..6
//   out_valid/out_ready      frame handshake
//   err_frame                one-cycle framing error pulse
//
// Build option: define FEATLOAD_PASSTHRU_EN to drop the threshold table and
// take the two MSBs of s_data as the quantized value.
module breastcancer2b_feature_loader #(
    parameter int RAW_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [RAW_W-1:0] s_data,
    input  logic             s_last,
    input  logic             thr_we,
    input  logic [2:0]       thr_feat,
    input  logic [1:0]       thr_lvl,
    input  logic [RAW_W-1:0] thr_data,
    output logic [1:0]       q_a,
    output logic [1:0]       q_b,
    output logic [1:0]       q_c,
    output logic [1:0]       q_d,
    output logic [1:0]       q_e,
    output logic [1:0]       q_f,
    output logic [1:0]       q_g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_frame
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [2:0] idx_nxt;
    logic       err_nxt;
    logic       accept;
    logic [1:0] q_new;
    logic [1:0] slot [7];

    // Handshake outputs decode the state register only.
    assign s_ready   = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign accept    = s_valid && (state == COLLECT);

    assign q_a = slot[0];
    assign q_b = slot[1];
    assign q_c = slot[2];
    assign q_d = slot[3];
    assign q_e = slot[4];
    assign q_f = slot[5];
    assign q_g = slot[6];

`ifdef FEATLOAD_PASSTHRU_EN

    assign q_new = s_data[RAW_W-1:RAW_W-2];

    logic passthru_unused;
    assign passthru_unused = ^{thr_we, thr_feat, thr_lvl, thr_data, s_data};

`else

    logic [RAW_W-1:0] thr [7][3];
    logic [RAW_W-1:0] t0;
    logic [RAW_W-1:0] t1;
    logic [RAW_W-1:0] t2;

    // Reset defaults split the input range into quarters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < 7; f++) begin
                for (int k = 0; k < 3; k++) begin
                    thr[f][k] <= RAW_W'(k + 1) << (RAW_W - 2);
                end
            end
        end else if (thr_we && (thr_lvl != 2'd3)) begin
            for (int f = 0; f < 7; f++) begin
                for (int k = 0; k < 3; k++) begin
                    if ((thr_feat == 3'(f)) && (thr_lvl == 2'(k))) begin
                        thr[f][k] <= thr_data;
                    end
                end
            end
        end
    end

    // Thresholds need not be ordered, so count how many the sample clears
    // rather than searching for a bracket.
    always_comb begin
        t0 = '0;
        t1 = '0;
        t2 = '0;
        for (int f = 0; f < 7; f++) begin
            if (idx == 3'(f)) begin
                t0 = thr[f][0];
                t1 = thr[f][1];
                t2 = thr[f][2];
            end
        end
        q_new = {1'b0, (s_data >= t0)} + {1'b0, (s_data >= t1)} + {1'b0, (s_data >= t2)};
    end

`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_nxt   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    if ((idx == 3'd6) && s_last) begin
                        state_nxt = HOLD;
                        idx_nxt   = 3'd0;
                    end else if ((idx < 3'd6) && !s_last) begin
                        idx_nxt = idx + 3'd1;
                    end else begin
                        // s_last early or missing: drop the partial frame.
                        err_nxt = 1'b1;
                        idx_nxt = 3'd0;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= 3'd0;
            err_frame <= 1'b0;
            for (int f = 0; f < 7; f++) begin
                slot[f] <= 2'd0;
            end
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            err_frame <= err_nxt;
            for (int f = 0; f < 7; f++) begin
                if (accept && (idx == 3'(f))) begin
                    slot[f] <= q_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_breastcancer2b_feature_loader.sv
// Purpose : exercises the feature loader with directed frames and random traffic against a frame-level model.
// Latency : model expects out_valid one cycle after the 7th accept.
// Backpres: random out_ready stalls are applied during the random phase.
module tb_breastcancer2b_feature_loader;

    localparam int RAW_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [RAW_W-1:0] s_data = '0;
    logic             s_last = 1'b0;
    logic             thr_we = 1'b0;
    logic [2:0]       thr_feat = '0;
    logic [1:0]       thr_lvl = '0;
    logic [RAW_W-1:0] thr_data = '0;
    logic [1:0]       q_a, q_b, q_c, q_d, q_e, q_f, q_g;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             err_frame;
    logic [13:0]      qbus;

    assign qbus = {q_a, q_b, q_c, q_d, q_e, q_f, q_g};

    breastcancer2b_feature_loader #(.RAW_W(RAW_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .thr_we(thr_we), .thr_feat(thr_feat), .thr_lvl(thr_lvl), .thr_data(thr_data),
        .q_a(q_a), .q_b(q_b), .q_c(q_c), .q_d(q_d), .q_e(q_e), .q_f(q_f), .q_g(q_g),
        .out_valid(out_valid), .out_ready(out_ready), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit rand_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: counts samples in the current frame, keeps the
    // frame being built and the last completed frame.
    bit       m_hold, m_err, m_known;
    int       m_cnt;
    bit [1:0] m_q [7];
    bit [1:0] m_p [7];
    int       m_thr [7][3];

    function automatic bit [1:0] quant(input int x, input int f);
`ifdef FEATLOAD_PASSTHRU_EN
        return 2'(x >> (RAW_W - 2));
`else
        int n = 0;
        for (int k = 0; k < 3; k++) if (x >= m_thr[f][k]) n++;
        return 2'(n);
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_hold = 0; m_err = 0; m_cnt = 0; m_known = 1;
            for (int f = 0; f < 7; f++) begin
                m_q[f] = 0;
                for (int k = 0; k < 3; k++) m_thr[f][k] = (k + 1) * (1 << (RAW_W - 2));
            end
        end else begin
            m_err = 0;
            if (!m_hold) begin
                if (s_valid) begin
                    m_p[m_cnt] = quant(int'(s_data), m_cnt);
                    m_known = 0;
                    if (s_last && m_cnt == 6) begin
                        m_hold = 1; m_q = m_p; m_known = 1; m_cnt = 0;
                    end else if (!s_last && m_cnt < 6) begin
                        m_cnt++;
                    end else begin
                        m_err = 1; m_cnt = 0;
                    end
                end
            end else if (out_ready) begin
                m_hold = 0;
            end
            if (thr_we && thr_feat < 7 && thr_lvl < 3) m_thr[thr_feat][thr_lvl] = int'(thr_data);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("s_ready", s_ready, !m_hold);
            chk("out_valid", out_valid, m_hold);
            chk("err_frame", err_frame, m_err);
            if (m_known)
                chk("q_bus", qbus, {m_q[0], m_q[1], m_q[2], m_q[3], m_q[4], m_q[5], m_q[6]});
        end
    end

    always @(negedge clk) begin
        if (rand_en) out_ready = 1'($urandom % 2);
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [7:0] d, input bit l);
        int guard = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        if (rand_en && ($urandom % 4 == 0)) begin
            thr_we = 1'b1;
            thr_feat = 3'($urandom % 8);
            thr_lvl = 2'($urandom % 4);
            thr_data = 8'($urandom % 256);
        end
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("send_wait_bound", guard < 200, 1);
        @(negedge clk);
        s_valid = 1'b0;
        thr_we = 1'b0;
    endtask

    task automatic frame7(input logic [55:0] v);
        for (int i = 0; i < 7; i++) send(v[55 - 8*i -: 8], i == 6);
    endtask

    task automatic wr_thr(input logic [2:0] f, input logic [1:0] l, input logic [7:0] d);
        thr_we = 1'b1; thr_feat = f; thr_lvl = l; thr_data = d;
        @(negedge clk);
        thr_we = 1'b0;
    endtask

    initial begin
        logic [55:0] v;
        int mode, pos;

        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", qbus, 0);
        rst = 1'b0;
        @(negedge clk);

        // Default thresholds 64/128/192.
        frame7(56'h00_3F_40_7F_80_BF_FF);
        chk("dflt_out_valid", out_valid, 1);
        chk("dflt_q", qbus, 14'b00_00_01_01_10_10_11);
        @(negedge clk);
        chk("dflt_s_ready_after", s_ready, 1);

        // Backpressure: hold for 10 cycles with s_valid hammering.
        out_ready = 1'b0;
        frame7(56'h11_22_33_44_55_66_77);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'($urandom);
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_s_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", s_ready, 1);

        // Threshold write on feature 2.
        wr_thr(3'd2, 2'd0, 8'd10);
        wr_thr(3'd2, 2'd1, 8'd20);
        wr_thr(3'd2, 2'd2, 8'd30);
        frame7(56'h00_00_19_00_00_00_00);
`ifdef FEATLOAD_PASSTHRU_EN
        chk("thr_q_c", q_c, 0);
`else
        chk("thr_q_c", q_c, 2);
`endif
        @(negedge clk);
        wr_thr(3'd7, 2'd0, 8'd0);
        wr_thr(3'd1, 2'd3, 8'd0);
`ifdef FEATLOAD_PASSTHRU_EN
        chk("bad_wr_q", qbus, 14'b0);
`else
        chk("bad_wr_q", qbus, 14'b00_00_10_00_00_00_00);
`endif
        frame7(56'h40_40_40_40_40_40_40);
`ifdef FEATLOAD_PASSTHRU_EN
        chk("bad_wr_frame", qbus, 14'b01_01_01_01_01_01_01);
`else
        chk("bad_wr_frame", qbus, 14'b01_01_11_01_01_01_01);
`endif
        @(negedge clk);

        // Framing errors: early s_last, then missing s_last.
        for (int i = 0; i < 4; i++) send(8'hA0, i == 3);
        chk("early_err", err_frame, 1);
        chk("early_no_valid", out_valid, 0);
        @(negedge clk);
        chk("early_err_once", err_frame, 0);
        frame7(56'hFF_FF_FF_FF_FF_FF_FF);
        chk("recover_valid", out_valid, 1);
        @(negedge clk);
        for (int i = 0; i < 7; i++) send(8'h80, 1'b0);
        chk("nolast_err", err_frame, 1);
        chk("nolast_no_valid", out_valid, 0);
        @(negedge clk);

        // Reset while holding a frame.
        out_ready = 1'b0;
        frame7(56'hFF_FF_FF_FF_FF_FF_FF);
        chk("hold_before_rst", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_ready", s_ready, 1);
        chk("rst_hold_q", qbus, 0);
        out_ready = 1'b1;
        frame7(56'h00_3F_40_7F_80_BF_FF);
        chk("rst_thr_default", qbus, 14'b00_00_01_01_10_10_11);
        @(negedge clk);

        // 0xC5 is 197: top bits 3, and above 192 with default thresholds.
        frame7(56'hC5_C5_C5_C5_C5_C5_C5);
        chk("c5_q", qbus, 14'h3FFF);
        @(negedge clk);

        // Random traffic with stalls, threshold writes and framing errors.
        rand_en = 1'b1;
        for (int fr = 0; fr < 60; fr++) begin
            mode = $urandom % 8;
            pos = $urandom % 6;
            for (int i = 0; i < 7; i++) begin
                repeat ($urandom % 3) @(negedge clk);
                if (mode == 0) begin
                    send(8'($urandom), i == pos);
                    if (i == pos) break;
                end else if (mode == 1) begin
                    send(8'($urandom), 1'b0);
                end else begin
                    send(8'($urandom), i == 6);
                end
            end
        end
        rand_en = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
